// File: rtl/alu_ctrl_md_unit.sv
// alu_ctrl_md_unit: registered ALU select decode plus an iterative
// multiply/divide sequencer that owns the HI/LO registers.
// Optional feature macro: ALU_CTL_MTHI_EN enables mthi/mtlo (funct 010001/010011).
module alu_ctrl_md_unit #(
  parameter int DATA_W  = 32,
  parameter int OPALU_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctl_valid,
  input  logic [OPALU_W-1:0] op_alu,
  input  logic [5:0]         funct,
  input  logic [DATA_W-1:0]  a_in,
  input  logic [DATA_W-1:0]  b_in,
  output logic [3:0]         alu_ctl,
  output logic               illegal,
  output logic               stall,
  output logic               md_busy,
  output logic               md_done,
  output logic [DATA_W-1:0]  hi_out,
  output logic [DATA_W-1:0]  lo_out
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         dec_ctl;
  logic               dec_ill;
  logic               is_rtype;
  logic               md_req;
  logic               dec_en;
  // shared iteration registers: acc is the partial product high half / remainder,
  // sh holds the multiplier / quotient, opb the multiplicand / divisor magnitude
  logic [DATA_W:0]    acc;
  logic [DATA_W-1:0]  sh;
  logic [DATA_W-1:0]  opb;
  logic               neg_a;
  logic               neg_b;
  logic               is_div;
  logic [DATA_W:0]    mul_sum;
  logic [DATA_W:0]    div_shift;
  logic [DATA_W:0]    div_diff;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]  quo_s;
  logic [DATA_W-1:0]  rem_s;
  logic               md_signed;
  logic               a_neg;
  logic               b_neg;
`ifdef ALU_CTL_MTHI_EN
  logic               mt_req;
`endif

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign is_rtype  = (op_alu == OPALU_W'(2));
  assign md_req    = ctl_valid & is_rtype & (funct[5:2] == 4'b0110);
`ifdef ALU_CTL_MTHI_EN
  assign mt_req    = ctl_valid & is_rtype & ((funct == 6'b010001) | (funct == 6'b010011));
`endif
  assign md_busy   = (state != S_IDLE);
  assign stall     = md_busy & ctl_valid & is_rtype &
                     ((funct == 6'b010000) | (funct == 6'b010010) |
                      (funct == 6'b010001) | (funct == 6'b010011) |
                      (funct[5:2] == 4'b0110));
  assign dec_en    = ctl_valid & ~stall;
  // multu/divu have funct[0] set
  assign md_signed = ~funct[0];
  assign a_neg     = md_signed & a_in[DATA_W-1];
  assign b_neg     = md_signed & b_in[DATA_W-1];

  // Decode op_alu/funct into the ALU select code and illegal flag
  always_comb begin
    dec_ctl = 4'b0000;
    dec_ill = 1'b0;
    case (op_alu)
      OPALU_W'(0): dec_ctl = 4'b0010;
      OPALU_W'(1): dec_ctl = 4'b0110;
      OPALU_W'(3): dec_ctl = 4'b0000;
      OPALU_W'(4): dec_ctl = 4'b0001;
      OPALU_W'(5): dec_ctl = 4'b0111;
      OPALU_W'(2): begin
        case (funct)
          6'b100000, 6'b100001: dec_ctl = 4'b0010;
          6'b100010, 6'b100011: dec_ctl = 4'b0110;
          6'b100100:            dec_ctl = 4'b0000;
          6'b100101:            dec_ctl = 4'b0001;
          6'b100110:            dec_ctl = 4'b0011;
          6'b100111:            dec_ctl = 4'b1100;
          6'b101010:            dec_ctl = 4'b0111;
          6'b101011:            dec_ctl = 4'b1000;
          6'b000000:            dec_ctl = 4'b0100;
          6'b000010:            dec_ctl = 4'b0101;
          6'b010000:            dec_ctl = 4'b1101;
          6'b010010:            dec_ctl = 4'b1110;
          6'b011000, 6'b011001,
          6'b011010, 6'b011011: dec_ctl = 4'b1111;
`ifdef ALU_CTL_MTHI_EN
          6'b010001, 6'b010011: dec_ctl = 4'b1111;
`endif
          default:              dec_ill = 1'b1;
        endcase
      end
      default: dec_ctl = 4'b0000;
    endcase
  end

  // Iteration arithmetic and final sign correction
  always_comb begin
    mul_sum   = acc + {1'b0, (sh[0] ? opb : {DATA_W{1'b0}})};
    div_shift = {acc[DATA_W-1:0], sh[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opb};
    prod_s    = neg_2w({acc[DATA_W-1:0], sh}, neg_a ^ neg_b);
    quo_s     = neg_w(sh, neg_a ^ neg_b);
    rem_s     = neg_w(acc[DATA_W-1:0], neg_a);
  end

  // Register the decoded select; hold it when no request is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctl <= 4'b0000;
      illegal <= 1'b0;
    end else begin
      illegal <= dec_en & dec_ill;
      if (dec_en) alu_ctl <= dec_ctl;
    end
  end

  // Operand latch on accept, then shift-add or restoring-divide steps
  always_ff @(posedge clk) begin
    if (state == S_IDLE && md_req) begin
      acc    <= '0;
      sh     <= neg_w(a_in, a_neg);
      opb    <= neg_w(b_in, b_neg);
      neg_a  <= a_neg;
      neg_b  <= b_neg;
      is_div <= funct[1];
    end else if (state == S_MUL) begin
      {acc, sh} <= {mul_sum, sh} >> 1;
    end else if (state == S_DIV && opb != '0) begin
      if (!div_diff[DATA_W]) begin
        acc <= div_diff;
        sh  <= {sh[DATA_W-2:0], 1'b1};
      end else begin
        acc <= div_shift;
        sh  <= {sh[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Sequencer FSM; HI/LO are written in DONE (or by mthi/mtlo when enabled)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      md_done <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      md_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (md_req) begin
            state <= funct[1] ? S_DIV : S_MUL;
            cnt   <= CNT_W'(DATA_W);
          end
`ifdef ALU_CTL_MTHI_EN
          else if (mt_req) begin
            if (funct[1]) lo_out <= a_in;
            else          hi_out <= a_in;
          end
`endif
        end
        S_MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_DONE;
        end
        S_DIV: begin
          if (opb == '0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) state <= S_DONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          md_done <= 1'b1;
          if (!is_div) begin
            hi_out <= prod_s[2*DATA_W-1:DATA_W];
            lo_out <= prod_s[DATA_W-1:0];
          end else if (opb == '0) begin
            // sh still holds |a|; restore the original dividend into HI
            hi_out <= neg_w(sh, neg_a);
            lo_out <= {DATA_W{1'b1}};
          end else begin
            hi_out <= rem_s;
            lo_out <= quo_s;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md_unit.sv
// Testbench for alu_ctrl_md_unit: decode vector table plus multi-cycle sequences.
module tb_alu_ctrl_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctl_valid;
  logic [2:0]  op_alu;
  logic [5:0]  funct;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  alu_ctl;
  logic        illegal;
  logic        stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] ctl;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  alu_ctrl_md_unit #(.DATA_W(32), .OPALU_W(3)) dut (
    .clk(clk), .rst(rst), .ctl_valid(ctl_valid), .op_alu(op_alu), .funct(funct),
    .a_in(a_in), .b_in(b_in), .alu_ctl(alu_ctl), .illegal(illegal), .stall(stall),
    .md_busy(md_busy), .md_done(md_done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one mult/div, wait for md_done, check latency and HI/LO
  task automatic run_md(input string name, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input int exp_k,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int k;
    bit seen;
    ctl_valid = 1'b1; op_alu = 3'b010; funct = fn; a_in = a; b_in = b;
    tick();
    ctl_valid = 1'b0;
    chk({name, "_busy"}, {63'd0, md_busy}, 64'd1);
    k = 0;
    seen = 1'b0;
    while (k < 100 && !seen) begin
      tick();
      k++;
      if (md_done) seen = 1'b1;
    end
    chk({name, "_lat"}, seen ? 64'(k) : 64'hDEAD, 64'(exp_k));
    chk({name, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
    chk({name, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
    chk({name, "_idle"}, {63'd0, md_busy}, 64'd0);
  endtask

  initial begin
    int k;
    bit stall_bad;
    logic [31:0] hi_keep;

    rst = 1'b1; ctl_valid = 1'b0; op_alu = 3'b000; funct = 6'd0; a_in = '0; b_in = '0;
    #3;
    chk("rst_ctl", {60'd0, alu_ctl}, 64'd0);
    chk("rst_ill", {63'd0, illegal}, 64'd0);
    chk("rst_busy", {63'd0, md_busy}, 64'd0);
    chk("rst_done", {63'd0, md_done}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    #4;
    rst = 1'b0;

    tbl.push_back('{3'b000, 6'b000000, 4'b0010, 1'b0});
    tbl.push_back('{3'b001, 6'b111111, 4'b0110, 1'b0});
    tbl.push_back('{3'b011, 6'b000000, 4'b0000, 1'b0});
    tbl.push_back('{3'b100, 6'b000000, 4'b0001, 1'b0});
    tbl.push_back('{3'b101, 6'b000000, 4'b0111, 1'b0});
    tbl.push_back('{3'b110, 6'b000000, 4'b0000, 1'b0});
    tbl.push_back('{3'b111, 6'b100000, 4'b0000, 1'b0});
    tbl.push_back('{3'b010, 6'b100000, 4'b0010, 1'b0});
    tbl.push_back('{3'b010, 6'b100001, 4'b0010, 1'b0});
    tbl.push_back('{3'b010, 6'b100011, 4'b0110, 1'b0});
    tbl.push_back('{3'b010, 6'b100100, 4'b0000, 1'b0});
    tbl.push_back('{3'b010, 6'b100101, 4'b0001, 1'b0});
    tbl.push_back('{3'b010, 6'b100110, 4'b0011, 1'b0});
    tbl.push_back('{3'b010, 6'b100111, 4'b1100, 1'b0});
    tbl.push_back('{3'b010, 6'b101010, 4'b0111, 1'b0});
    tbl.push_back('{3'b010, 6'b000000, 4'b0100, 1'b0});
    tbl.push_back('{3'b010, 6'b000010, 4'b0101, 1'b0});
    tbl.push_back('{3'b010, 6'b010000, 4'b1101, 1'b0});
    tbl.push_back('{3'b010, 6'b010010, 4'b1110, 1'b0});
    tbl.push_back('{3'b010, 6'b000001, 4'b0000, 1'b1});
    tbl.push_back('{3'b010, 6'b100010, 4'b0110, 1'b0});
    tbl.push_back('{3'b010, 6'b101011, 4'b1000, 1'b0});
    tbl.push_back('{3'b010, 6'b111111, 4'b0000, 1'b1});

    foreach (tbl[i]) begin
      ctl_valid = 1'b1; op_alu = tbl[i].op; funct = tbl[i].fn;
      tick();
      chk($sformatf("vec%0d_ctl", i), {60'd0, alu_ctl}, {60'd0, tbl[i].ctl});
      chk($sformatf("vec%0d_ill", i), {63'd0, illegal}, {63'd0, tbl[i].ill});
    end

    // No request: select holds, illegal drops
    ctl_valid = 1'b0; op_alu = 3'b000; funct = 6'b100000;
    tick();
    chk("hold_ctl", {60'd0, alu_ctl}, 64'd0);
    chk("hold_ill", {63'd0, illegal}, 64'd0);

    run_md("mult_neg", 6'b011000, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu", 6'b011001, 32'hFFFFFFFD, 32'd7, 33, 32'h00000006, 32'hFFFFFFEB);
    run_md("div_neg", 6'b011010, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_negb", 6'b011010, 32'd7, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
    run_md("divu", 6'b011011, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_md("divu_z", 6'b011011, 32'd7, 32'd0, 2, 32'd7, 32'hFFFFFFFF);
    run_md("div_z", 6'b011010, 32'hFFFFFFFB, 32'd0, 2, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_md("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0, 32'h80000000);

    // Asynchronous reset in the middle of a multiply
    ctl_valid = 1'b1; op_alu = 3'b010; funct = 6'b011000; a_in = 32'd9; b_in = 32'd9;
    tick();
    ctl_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, md_busy}, 64'd0);
    chk("arst_hilo", {hi_out, lo_out}, 64'd0);
    chk("arst_ctl", {60'd0, alu_ctl}, 64'd0);
    #2;
    rst = 1'b0;
    run_md("mult_after_rst", 6'b011000, 32'd3, 32'd4, 33, 32'd0, 32'd12);

    // mflo issued while a multiply is running stalls until DONE
    ctl_valid = 1'b1; op_alu = 3'b010; funct = 6'b011000; a_in = 32'd5; b_in = 32'd6;
    tick();
    ctl_valid = 1'b0;
    repeat (2) tick();
    ctl_valid = 1'b1; op_alu = 3'b010; funct = 6'b010010;
    #1;
    chk("mflo_stall", {63'd0, stall}, 64'd1);
    k = 2;
    stall_bad = 1'b0;
    while (k < 100 && !md_done) begin
      tick();
      k++;
      if (!md_done && (!stall || alu_ctl != 4'b1111)) stall_bad = 1'b1;
    end
    chk("mflo_lat", 64'(k), 64'd33);
    chk("mflo_held", {63'd0, stall_bad}, 64'd0);
    chk("mflo_unstall", {63'd0, stall}, 64'd0);
    chk("mflo_ctl_pre", {60'd0, alu_ctl}, 64'hF);
    tick();
    ctl_valid = 1'b0;
    chk("mflo_ctl", {60'd0, alu_ctl}, 64'hE);
    chk("mflo_lo", {32'd0, lo_out}, 64'd30);
    tick();
    chk("mflo_lo_stable", {32'd0, lo_out}, 64'd30);

    // mthi / mtlo
    hi_keep = hi_out;
    ctl_valid = 1'b1; op_alu = 3'b010; funct = 6'b010001; a_in = 32'h1234;
    tick();
    ctl_valid = 1'b0;
`ifdef ALU_CTL_MTHI_EN
    chk("mthi_hi", {32'd0, hi_out}, 64'h1234);
    chk("mthi_ctl", {60'd0, alu_ctl}, 64'hF);
    chk("mthi_ill", {63'd0, illegal}, 64'd0);
    chk("mthi_done", {63'd0, md_done}, 64'd0);
    ctl_valid = 1'b1; funct = 6'b010011; a_in = 32'h55;
    tick();
    ctl_valid = 1'b0;
    chk("mtlo_lo", {32'd0, lo_out}, 64'h55);
`else
    chk("mthi_hi", {32'd0, hi_out}, {32'd0, hi_keep});
    chk("mthi_ctl", {60'd0, alu_ctl}, 64'h0);
    chk("mthi_ill", {63'd0, illegal}, 64'd1);
    ctl_valid = 1'b1; funct = 6'b010011; a_in = 32'h55;
    tick();
    ctl_valid = 1'b0;
    chk("mtlo_lo", {32'd0, lo_out}, 64'd30);
    chk("mtlo_ill", {63'd0, illegal}, 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
